// File: rtl/thread_scheduler_pkg.sv
// Shared constants for the barrel-thread scheduler and its round-robin picker.
// Default thread count, pipeline spacing, reset PC and the sequential fetch step.
package thread_scheduler_pkg;

    localparam int          NUM_THREADS   = 4;
    localparam int          TID_WIDTH     = 2;
    localparam int          PIPE_DEPTH    = 4;
    localparam int          ADDRESS_WIDTH = 32;
    localparam int unsigned RESET_PC      = 0;
    localparam int unsigned PC_INC        = 4;

endpackage

// File: rtl/thread_scheduler_rr_picker.sv
// Combinational round-robin picker: first set bit of eligible after last_tid, wrapping.
// Zero latency; no flow control, found=0 when the mask is empty.
import thread_scheduler_pkg::*;

module rr_picker #(
    parameter int N  = NUM_THREADS,
    parameter int TW = TID_WIDTH
) (
    input  logic [N-1:0]  eligible,
    input  logic [TW-1:0] last_tid,
    output logic          found,
    output logic [TW-1:0] pick_tid
);

    logic [TW-1:0] idx;

    // k runs 1..N so last_tid itself is tried last; N must be 2**TW for the wrap.
    always_comb begin
        found    = 1'b0;
        pick_tid = last_tid;
        idx      = last_tid;
        for (int k = 1; k <= N; k++) begin
            idx = last_tid + TW'(k);
            if (!found && eligible[idx]) begin
                found    = 1'b1;
                pick_tid = idx;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Barrel-thread fetch scheduler: round-robin issue among active, unstalled, cooled-down threads.
// One cycle from pick to issue outputs; stalled or cooling threads are simply skipped.
module thread_scheduler #(
    parameter int NUM_THREADS   = thread_scheduler_pkg::NUM_THREADS,
    parameter int ADDRESS_WIDTH = thread_scheduler_pkg::ADDRESS_WIDTH,
    parameter int TID_WIDTH     = thread_scheduler_pkg::TID_WIDTH,
    parameter int PIPE_DEPTH    = thread_scheduler_pkg::PIPE_DEPTH,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(thread_scheduler_pkg::RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_valid,
    input  logic [TID_WIDTH-1:0]     start_tid,
    input  logic [ADDRESS_WIDTH-1:0] start_pc,
    input  logic                     halt_valid,
    input  logic [TID_WIDTH-1:0]     halt_tid,
    input  logic [NUM_THREADS-1:0]   thread_stall,
    input  logic                     redirect_valid,
    input  logic [TID_WIDTH-1:0]     redirect_tid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     issue_valid,
    output logic [TID_WIDTH-1:0]     issue_tid,
    output logic [ADDRESS_WIDTH-1:0] issue_pc,
    output logic [NUM_THREADS-1:0]   active_mask
);

    import thread_scheduler_pkg::*;

    localparam int               CD_W   = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [CD_W-1:0]  CD_MAX = CD_W'(PIPE_DEPTH - 1);

    logic [NUM_THREADS-1:0]   active;
    logic [ADDRESS_WIDTH-1:0] pc       [NUM_THREADS];
    logic [CD_W-1:0]          cooldown [NUM_THREADS];
    logic [TID_WIDTH-1:0]     last_tid;

    logic [NUM_THREADS-1:0]   eligible;
    logic [NUM_THREADS-1:0]   pick_hit;
    logic [NUM_THREADS-1:0]   redir_hit;
    logic [NUM_THREADS-1:0]   start_hit;
    logic [NUM_THREADS-1:0]   halt_hit;
    logic                     found;
    logic [TID_WIDTH-1:0]     pick_tid;

    rr_picker #(
        .N  (NUM_THREADS),
        .TW (TID_WIDTH)
    ) u_picker (
        .eligible (eligible),
        .last_tid (last_tid),
        .found    (found),
        .pick_tid (pick_tid)
    );

    // Halt beats a same-tid start; a redirect only lands on a thread already active.
    always_comb begin
        eligible  = '0;
        pick_hit  = '0;
        redir_hit = '0;
        start_hit = '0;
        halt_hit  = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            eligible[i]  = active[i] && !thread_stall[i] && (cooldown[i] == '0);
            pick_hit[i]  = found && (pick_tid == TID_WIDTH'(i));
            halt_hit[i]  = halt_valid && (halt_tid == TID_WIDTH'(i));
            redir_hit[i] = redirect_valid && (redirect_tid == TID_WIDTH'(i)) && active[i];
            start_hit[i] = start_valid && (start_tid == TID_WIDTH'(i)) && !active[i]
                           && !halt_hit[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active      <= NUM_THREADS'(1);
            last_tid    <= TID_WIDTH'(NUM_THREADS - 1);
            issue_valid <= 1'b0;
            issue_tid   <= '0;
            issue_pc    <= '0;
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc[i]       <= (i == 0) ? RESET_PC : '0;
                cooldown[i] <= '0;
            end
        end else begin
            issue_valid <= found;
            if (found) begin
                issue_tid <= pick_tid;
                issue_pc  <= pc[pick_tid];
                last_tid  <= pick_tid;
            end
            // Later assignments take priority: pick < redirect < start < halt.
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (cooldown[i] != '0) begin
                    cooldown[i] <= cooldown[i] - CD_W'(1);
                end
                if (pick_hit[i]) begin
                    pc[i]       <= pc[i] + ADDRESS_WIDTH'(PC_INC);
                    cooldown[i] <= CD_MAX;
                end
                if (redir_hit[i]) begin
                    pc[i] <= redirect_pc;
                end
                if (start_hit[i]) begin
                    active[i]   <= 1'b1;
                    pc[i]       <= start_pc;
                    cooldown[i] <= '0;
                end
                if (halt_hit[i]) begin
                    active[i] <= 1'b0;
                end
            end
        end
    end

    assign active_mask = active;

endmodule
